// File: rtl/tmds_pkg.sv
// rtl/tmds_pkg.sv - shared TMDS control tokens, CD/token mapping and lock defaults
package tmds_pkg;

  localparam int LOCK_TOKENS_DEFAULT    = 16;
  localparam int SEARCH_TIMEOUT_DEFAULT = 1024;

  // Control tokens written as word[9:0]; bit 0 is the first bit on the wire.
  localparam logic [9:0] TOKEN_CD00 = 10'b1101010100;
  localparam logic [9:0] TOKEN_CD01 = 10'b0010101011;
  localparam logic [9:0] TOKEN_CD10 = 10'b0101010100;
  localparam logic [9:0] TOKEN_CD11 = 10'b1010101011;

  typedef enum logic [1:0] {
    ST_SEARCH,
    ST_CHECK,
    ST_LOCKED
  } lock_state_t;

  // Transmit direction: control value {CD1,CD0} to its token.
  function automatic logic [9:0] cd_to_token(input logic [1:0] cd);
    case (cd)
      2'b00:   return TOKEN_CD00;
      2'b01:   return TOKEN_CD01;
      2'b10:   return TOKEN_CD10;
      default: return TOKEN_CD11;
    endcase
  endfunction

  function automatic logic is_token(input logic [9:0] w);
    return (w == TOKEN_CD00) || (w == TOKEN_CD01) ||
           (w == TOKEN_CD10) || (w == TOKEN_CD11);
  endfunction

  // Receive direction: token to control value; only meaningful when is_token(w).
  function automatic logic [1:0] token_to_cd(input logic [9:0] w);
    case (w)
      TOKEN_CD01: return 2'b01;
      TOKEN_CD10: return 2'b10;
      TOKEN_CD11: return 2'b11;
      default:    return 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/tmds_word_decode.sv
// rtl/tmds_word_decode.sv - registered decode of one aligned TMDS word
module tmds_word_decode
  import tmds_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] aw,
  output logic       de,
  output logic [7:0] d,
  output logic [1:0] c
);

  logic [7:0] q;
  logic [7:0] dec;

  // Undo the optional inversion (bit 9), then the XOR/XNOR chain (bit 8 selects).
  always_comb begin
    q      = aw[9] ? ~aw[7:0] : aw[7:0];
    dec    = 8'h00;
    dec[0] = q[0];
    for (int i = 1; i < 8; i++) begin
      dec[i] = aw[8] ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
    end
  end

  // Tokens update the control value and blank the byte; data words keep c.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      de <= 1'b0;
      d  <= 8'h00;
      c  <= 2'b00;
    end else if (is_token(aw)) begin
      de <= 1'b0;
      d  <= 8'h00;
      c  <= token_to_cd(aw);
    end else begin
      de <= 1'b1;
      d  <= dec;
    end
  end

endmodule

// File: rtl/tmds_channel_decoder.sv
// rtl/tmds_channel_decoder.sv - TMDS word aligner, lock FSM and channel decode
module tmds_channel_decoder
  import tmds_pkg::*;
#(
  parameter int LOCK_TOKENS    = LOCK_TOKENS_DEFAULT,
  parameter int SEARCH_TIMEOUT = SEARCH_TIMEOUT_DEFAULT,
  parameter int CNT_W          = 11
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] tmds_word,
  output logic       de,
  output logic [7:0] d,
  output logic [1:0] c,
  output logic       locked,
  output logic [3:0] offset
);

  localparam int RUN_W = $clog2(LOCK_TOKENS + 1);

  logic [9:0]       prev_word;
  logic [9:0]       aw;
  logic [19:0]      window;
  logic [9:0]       aligned;
  lock_state_t      state;
  logic [CNT_W-1:0] timer;
  logic [RUN_W-1:0] run;
  logic [RUN_W-1:0] run_inc;
  logic [3:0]       next_offset;
  logic             token;
  logic             timeout;
  logic             lock_hit;

  assign window = {tmds_word, prev_word};

  // Pick the 10-bit slice starting at the current bit offset.
  always_comb begin
    aligned = window[9:0];
    for (int k = 0; k < 10; k++) begin
      if (offset == 4'(k)) aligned = window[k +: 10];
    end
  end

  // Window history and aligned-word pipeline stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_word <= 10'd0;
      aw        <= 10'd0;
    end else begin
      prev_word <= tmds_word;
      aw        <= aligned;
    end
  end

  assign token       = is_token(aw);
  assign timeout     = (timer == CNT_W'(SEARCH_TIMEOUT - 1));
  assign run_inc     = (run == RUN_W'(LOCK_TOKENS)) ? run : run + RUN_W'(1);
  assign lock_hit    = token && (run_inc == RUN_W'(LOCK_TOKENS));
  assign next_offset = (offset == 4'd9) ? 4'd0 : offset + 4'd1;

  // Lock FSM: the search timer is free-running per offset; lock beats timeout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_SEARCH;
      run    <= '0;
      timer  <= '0;
      offset <= 4'd0;
      locked <= 1'b0;
    end else begin
      case (state)
        ST_SEARCH, ST_CHECK: begin
          if (lock_hit) begin
            state  <= ST_LOCKED;
            locked <= 1'b1;
            timer  <= '0;
            run    <= run_inc;
          end else if (timeout) begin
            state  <= ST_SEARCH;
            offset <= next_offset;
            timer  <= '0;
            run    <= '0;
          end else begin
            timer <= timer + CNT_W'(1);
            if (token) begin
              state <= ST_CHECK;
              run   <= run_inc;
            end else begin
              state <= ST_SEARCH;
              run   <= '0;
            end
          end
        end
        ST_LOCKED: begin
          if (token) begin
            timer <= '0;
          end else if (timeout) begin
            state  <= ST_SEARCH;
            locked <= 1'b0;
            offset <= next_offset;
            timer  <= '0;
            run    <= '0;
          end else begin
            timer <= timer + CNT_W'(1);
          end
        end
        default: state <= ST_SEARCH;
      endcase
    end
  end

  tmds_word_decode u_word_decode (
    .clk   (clk),
    .rst_n (rst_n),
    .aw    (aw),
    .de    (de),
    .d     (d),
    .c     (c)
  );

endmodule
